cb_pingpong_buf: RTL
====================

# cb_pingpong_buf

Double-buffered code-block store between the code-block segmentation stage and the turbo encoder / interleaver. It captures the segmenter's byte stream (`cb_data`, `cb_size`, `start`) one code block at a time into one of two banks. It then replays each completed block to the downstream consumer under a valid/ready handshake. Filling one bank while the other drains decouples the segmenter's free-running output from encoder backpressure.

## Interface
Parameters:
- `K_SMALL_BYTES`, 132: block length in bytes when `cb_size`=0 (1056 bits).
- `K_LARGE_BYTES`, 768: block length in bytes when `cb_size`=1 (6144 bits).
- `CNT_W`, 10: width of byte counters; must hold `K_LARGE_BYTES`.

Ports:
- `clk`  in  1  single clock for the whole block.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  byte on `in_data` is valid this cycle (segmenter write request).
- `in_data`  in  8  code-block byte (segmenter `cb_data`, MSB first in time).
- `in_start`  in  1  qualifies the first byte of a block; sampled only with `in_valid`.
- `in_size`  in  1  block size select; sampled only with `in_valid & in_start`.
- `out_valid`  out  1  `out_data` holds a valid byte.
- `out_ready`  in  1  consumer accepts the byte this cycle.
- `out_data`  out  8  block byte.
- `out_start`  out  1  first byte of a block.
- `out_last`  out  1  final byte of a block.
- `out_size`  out  1  size of the block being output.
- `bank_full`  out  2  per-bank full flags (status).
- `overflow`  out  1  sticky: a block was dropped because both banks were full.
- `err_start`  out  1  sticky: `in_start` arrived before the current block completed.

## Operation
- Storage is two banks of `K_LARGE_BYTES` x 8 with synchronous read. Each bank has a full flag and a latched size bit.
- Write FSM states:
  - W_IDLE: on `in_valid & in_start`, pick the bank `wr_bank` when it is not full; otherwise pick the other bank when it is free; otherwise set `overflow` and ignore bytes until the next `in_start`. The start byte is written at address 0, `wr_cnt`=1, size is latched, and the FSM goes to W_FILL. `in_valid` without `in_start` is ignored.
  - W_FILL: each `in_valid` writes at `wr_cnt` and increments it. When the byte at address len-1 is written, the bank's full flag is set, `wr_bank` toggles, and the FSM returns to W_IDLE.
  - `in_valid & in_start` in W_FILL: set `err_start`, discard the partial block, and restart at address 0 of the same bank with the new size.
- Read FSM states:
  - R_IDLE: when `bank_full[rd_bank]` is set, issue a read of address 0 and go to R_STREAM.
  - R_STREAM: the output register is loaded from the bank whenever it is empty or accepted (`out_valid & out_ready`), giving one byte per cycle at full throughput. `out_start` is set when `rd_cnt`=0. `out_last` is set when `rd_cnt`=len-1.
  - When the last byte is accepted, the bank's full flag is cleared, `rd_bank` toggles, and the FSM returns to R_IDLE.
- Banks are consumed in the order they were filled.
- A release in cycle N is visible to the write side in the same cycle N (bypass), so a start in that cycle does not overflow.
- Counters wrap only by returning to 0 on block completion; they never exceed len-1.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `out_start`=0, `out_last`=0, `out_size`=0, `bank_full`=00, `overflow`=0, `err_start`=0, `wr_bank`=`rd_bank`=0, both FSMs idle.
- Reset asserted mid-operation discards all banks and partial blocks on the next edge.
- Fill: if the last input byte is written at edge N, `bank_full` rises at N+1.
- Read latency: the read FSM sees full at N+1 and issues address 0. `out_valid` rises with the first byte at edge N+2.
- Output stability: while `out_valid & !out_ready`, `out_data`, `out_start`, `out_last` and `out_size` are held stable.
- Back-to-back blocks: after `out_last` is accepted at edge M, if the other bank is full its first byte is valid at M+2 (one bubble cycle).
- Simultaneous write completion and read release in the same cycle are both honoured.

## Test plan
- Small block: start + 132 bytes 0x00..0x83 with `out_ready`=1 -> `out_valid` 2 cycles after the last write; 132 bytes output in order; `out_start` on 0x00; `out_last` on 0x83; `out_size`=0.
- Ping-pong: with `out_ready`=0, write a large block (768 bytes) then a small block -> `bank_full`=11. Raise `out_ready` -> large block, one bubble, small block; `overflow`=0.
- Overflow: both banks full, third `in_start` -> `overflow`=1; third block's bytes never appear; the first two blocks are intact.
- Backpressure: toggle `out_ready` 1010... over a 132-byte block -> every byte delivered exactly once, and data is held stable while stalled.
- Early restart: `in_start` at byte 50 of a large block, then a full small block -> `err_start`=1; only the small block is output.
- Reset during streaming at byte 300 of 768 -> all outputs return to reset values next cycle; a subsequent block outputs correctly from address 0.

Source files
------------

// File: rtl/cb_pingpong_buf_if.sv
// Byte-stream ports of the code-block ping-pong buffer.
// The master drives the segmenter side and accepts the output stream; the slave is the buffer.
interface cb_pingpong_buf_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_start;
    logic       in_size;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_start;
    logic       out_last;
    logic       out_size;

    modport master (
        output in_valid, in_data, in_start, in_size, out_ready,
        input  out_valid, out_data, out_start, out_last, out_size
    );

    modport slave (
        input  in_valid, in_data, in_start, in_size, out_ready,
        output out_valid, out_data, out_start, out_last, out_size
    );
endinterface

// File: rtl/cb_pingpong_buf.sv
// Two-bank code-block store: the segmenter fills one bank while the other
// is replayed to the encoder under valid/ready.
module cb_pingpong_buf #(
    parameter int K_SMALL_BYTES = 132,
    parameter int K_LARGE_BYTES = 768,
    parameter int CNT_W         = 10
) (
    input  logic             clk,
    input  logic             reset,
    cb_pingpong_buf_if.slave bus,
    output logic [1:0]       bank_full,
    output logic             overflow,
    output logic             err_start
);

    typedef enum logic {W_IDLE, W_FILL}   w_state_e;
    typedef enum logic {R_IDLE, R_STREAM} r_state_e;

    w_state_e         w_state_q, w_state_d;
    r_state_e         r_state_q, r_state_d;
    logic             wr_bank_q, wr_bank_d;
    logic             fill_bank_q, fill_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [1:0]       full_q, full_d;
    logic [1:0]       size_q, size_d;
    logic             overflow_q, overflow_d;
    logic             err_start_q, err_start_d;
    logic             out_valid_q, out_valid_d;
    logic             out_start_q, out_start_d;
    logic             out_last_q, out_last_d;
    logic             out_size_q, out_size_d;
    logic [7:0]       out_data_q;

    logic [1:0]       rel_mask;
    logic [1:0]       full_avail;
    logic             start_go, start_bank;
    logic             mem_we, mem_wbank;
    logic [CNT_W-1:0] mem_waddr;
    logic             rd_en;
    logic [CNT_W-1:0] rd_addr;

    logic [7:0] mem [2][K_LARGE_BYTES];

    function automatic logic [CNT_W-1:0] len_m1(input logic sz);
        return sz ? CNT_W'(K_LARGE_BYTES - 1) : CNT_W'(K_SMALL_BYTES - 1);
    endfunction

    // Read side: the output register doubles as the bank's synchronous read register.
    always_comb begin
        r_state_d   = r_state_q;
        rd_bank_d   = rd_bank_q;
        rd_cnt_d    = rd_cnt_q;
        out_valid_d = out_valid_q;
        out_start_d = out_start_q;
        out_last_d  = out_last_q;
        out_size_d  = out_size_q;
        rel_mask    = 2'b00;
        rd_en       = 1'b0;
        rd_addr     = '0;
        if (r_state_q == R_IDLE) begin
            if (full_q[rd_bank_q]) begin
                rd_en       = 1'b1;
                rd_cnt_d    = '0;
                out_valid_d = 1'b1;
                out_start_d = 1'b1;
                out_last_d  = (len_m1(size_q[rd_bank_q]) == '0);
                out_size_d  = size_q[rd_bank_q];
                r_state_d   = R_STREAM;
            end
        end else if (bus.out_ready) begin
            if (out_last_q) begin
                rel_mask[rd_bank_q] = 1'b1;
                out_valid_d = 1'b0;
                out_start_d = 1'b0;
                out_last_d  = 1'b0;
                rd_bank_d   = ~rd_bank_q;
                r_state_d   = R_IDLE;
            end else begin
                rd_en       = 1'b1;
                rd_addr     = rd_cnt_q + CNT_W'(1);
                rd_cnt_d    = rd_addr;
                out_start_d = 1'b0;
                out_last_d  = (rd_addr == len_m1(out_size_q));
            end
        end
    end

    // Write side sees a bank released this cycle as already free.
    always_comb begin
        full_avail  = full_q & ~rel_mask;
        full_d      = full_avail;
        w_state_d   = w_state_q;
        wr_bank_d   = wr_bank_q;
        fill_bank_d = fill_bank_q;
        wr_cnt_d    = wr_cnt_q;
        size_d      = size_q;
        overflow_d  = overflow_q;
        err_start_d = err_start_q;
        start_go    = 1'b0;
        start_bank  = wr_bank_q;
        mem_we      = 1'b0;
        mem_wbank   = fill_bank_q;
        mem_waddr   = wr_cnt_q;
        if (bus.in_valid && bus.in_start) begin
            if (w_state_q == W_FILL) begin
                err_start_d = 1'b1;
                start_go    = 1'b1;
                start_bank  = fill_bank_q;
            end else if (!full_avail[wr_bank_q]) begin
                start_go    = 1'b1;
                start_bank  = wr_bank_q;
            end else if (!full_avail[~wr_bank_q]) begin
                start_go    = 1'b1;
                start_bank  = ~wr_bank_q;
            end else begin
                overflow_d  = 1'b1;
            end
        end
        if (start_go) begin
            mem_we              = 1'b1;
            mem_wbank           = start_bank;
            mem_waddr           = '0;
            fill_bank_d         = start_bank;
            size_d[start_bank]  = bus.in_size;
            wr_cnt_d            = CNT_W'(1);
            w_state_d           = W_FILL;
        end else if (bus.in_valid && w_state_q == W_FILL) begin
            mem_we = 1'b1;
            if (wr_cnt_q == len_m1(size_q[fill_bank_q])) begin
                full_d[fill_bank_q] = 1'b1;
                wr_bank_d           = ~fill_bank_q;
                wr_cnt_d            = '0;
                w_state_d           = W_IDLE;
            end else begin
                wr_cnt_d = wr_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_wbank][mem_waddr] <= bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (reset)      out_data_q <= '0;
        else if (rd_en) out_data_q <= mem[rd_bank_q][rd_addr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            wr_bank_q   <= 1'b0;
            fill_bank_q <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            full_q      <= 2'b00;
            size_q      <= 2'b00;
            overflow_q  <= 1'b0;
            err_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_start_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_size_q  <= 1'b0;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            wr_bank_q   <= wr_bank_d;
            fill_bank_q <= fill_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            full_q      <= full_d;
            size_q      <= size_d;
            overflow_q  <= overflow_d;
            err_start_q <= err_start_d;
            out_valid_q <= out_valid_d;
            out_start_q <= out_start_d;
            out_last_q  <= out_last_d;
            out_size_q  <= out_size_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_start = out_start_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_size  = out_size_q;
    assign bank_full     = full_q;
    assign overflow      = overflow_q;
    assign err_start     = err_start_q;

endmodule
